moore_seq_detect_n: RTL and testbench
=====================================

// Module: moore_seq_detect_n
// PURPOSE
//  Parametrised Moore serial sequence detector, next generation of the fixed 4-bit detector.
//  - Pattern width, overlap mode and default pattern set by parameters.
//  - Pattern reloadable at run time.
//  - Input qualified by a valid strobe.
//  - Optional saturating match counter.
//  Sits on a serial bit stream; out is a registered state output (Moore).
// PARAMETERS
//  PAT_W    4        pattern length in bits, 2..32
//  PATTERN  4'b1011  reset/default pattern; MSB is the first bit received
//  OVERLAP  1        1: matches may share bits; 0: history restarts after each match
//  CNT_W    8        match counter width (used only with MATCH_COUNT_EN)
// PORTS
//  clk          in   1      rising-edge clock
//  clear        in   1      synchronous active-high reset
//  in           in   1      serial data bit
//  in_valid     in   1      1 = in is sampled this edge; 0 = hold all state
//  pat_load     in   1      load pat_in as the new pattern
//  pat_in       in   PAT_W  new pattern, MSB first
//  out          out  1      1 while in MATCH state
//  match_count  out  CNT_W  saturating match count (MATCH_COUNT_EN only)
// BEHAVIOUR
//  - Reset (clear=1 at posedge):
//    - hist=0, fill=0, out=0, match_count=0; pattern register := PATTERN.
//    - clear has priority over everything else.
//  - pat_load=1 (clear=0):
//    - pat_reg := pat_in; hist, fill and out := 0; match_count kept.
//    - in is ignored on that edge.
//  - Accepted bit (in_valid=1, clear=0, pat_load=0):
//    - hist := {hist[PAT_W-2:0], in}.
//    - fill := min(fill+1, PAT_W).
//  - Match condition is evaluated on the next-state values:
//    - next_fill==PAT_W and next_hist==pat_reg; out is registered from this condition.
//  - Latency:
//    - out rises on the same edge that samples the last pattern bit.
//    - It is visible for that cycle and falls on the next accepted bit unless that bit also matches.
//  - in_valid=0: all state and out hold; a high out stays high.
//  - Overlap modes:
//    - OVERLAP=1: history is kept after a match, e.g. 1011011 -> 2 matches.
//    - OVERLAP=0: the match edge also forces fill:=0, so no match is possible within the next PAT_W-1 bits.
//  - States (Moore):
//    - FILLING (fill<PAT_W): out=0.
//    - ARMED (fill==PAT_W, no match): out=0.
//    - MATCH: out=1.
//    - MATCH -> FILLING on the next accepted bit when OVERLAP=0.
//  - match_count:
//    - +1 on each edge where out goes to, or stays at, 1 due to a new accepted bit.
//    - Saturates at 2^CNT_W-1; no wrap.
//  - Only clear and pat_load can change state on an edge without an accepted bit.
// CONFIGURATION
//  - MATCH_COUNT_EN defined: the counter is built and match_count is driven per above.
//  - MATCH_COUNT_EN undefined: no counter flops; match_count is tied to 0.
//  - The port list is the same in both builds.
// STRUCTURE
//  - Package moore_sd_pkg:
//    - State encoding localparams FILLING/ARMED/MATCH.
//    - Default pattern constant SD_PAT_1011 = 4'b1011.
//    - Saturating-increment function.
//  - One sub-module, sd_shift_hist:
//    - PAT_W-bit history shift register plus fill counter.
//    - Inputs: shift enable, flush.
//  - Top level holds the pattern register, match compare, out flop and optional counter.
// TESTING
//  1 - Reset then stream 1011001011 with in_valid=1:
//      out=1 after bit 4 and after bit 10 only; match_count=2.
//  2 - OVERLAP=1, stream 1011011: out=1 after bits 4 and 7.
//      OVERLAP=0, same stream: only bit 4 matches; count=1.
//  3 - in_valid=0 for 3 cycles right after a match:
//      out stays 1 and count is unchanged; next accepted 0 drops out.
//  4 - Mid-stream pat_load with pat_in=4'b0110, then stream 0110:
//      no match from the old history; out=1 after the 4th new bit.
//  5 - clear=1 while out=1:
//      next edge out=0, count=0, pattern returns to 1011; 101 then 1 matches again.
//  6 - CNT_W=2, MATCH_COUNT_EN on, 5 matches:
//      match_count saturates at 3.
//      Macro off: match_count==0 throughout.

Source files
------------

// File: rtl/moore_sd_pkg.sv
// Shared types and helpers for the parametrised Moore sequence detector.
// State encodings, the default pattern and a saturating increment.
package moore_sd_pkg;

    typedef logic [1:0] sd_state_t;

    localparam sd_state_t FILLING = 2'd0;
    localparam sd_state_t ARMED   = 2'd1;
    localparam sd_state_t MATCH   = 2'd2;

    localparam logic [3:0] SD_PAT_1011 = 4'b1011;

    // Returns v+1, holding at max_v once it has been reached.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sd_shift_hist.sv
// History shift register and saturating fill counter for the sequence detector.
// Exposes next-state values so the parent can compare before the edge.
module sd_shift_hist #(
    parameter int PAT_W  = 4,
    parameter int FILL_W = $clog2(PAT_W + 1)
) (
    input  logic              clk,
    input  logic              flush,
    input  logic              shift_en,
    input  logic              fill_rst,
    input  logic              in,
    output logic [PAT_W-1:0]  hist_nxt,
    output logic [FILL_W-1:0] fill_nxt
);

    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;

    // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
    always_comb begin
        hist_nxt = {hist[PAT_W-2:0], in};
        fill_nxt = (fill == FULL) ? FULL : fill + FILL_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (flush) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= hist_nxt;
            fill <= fill_rst ? '0 : fill_nxt;
        end
    end

endmodule

// File: rtl/moore_seq_detect_n.sv
// Parametrised Moore serial sequence detector with reloadable pattern.
// Define MATCH_COUNT_EN to build the saturating match counter.
module moore_seq_detect_n
    import moore_sd_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(SD_PAT_1011),
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             in,
    input  logic             in_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             out,
    output logic [CNT_W-1:0] match_count
);

    localparam int                FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  pat_reg;
    logic [PAT_W-1:0]  hist_nxt;
    logic [FILL_W-1:0] fill_nxt;
    logic              accept;
    logic              match_now;
    sd_state_t         state;
    sd_state_t         state_nxt;

    assign accept    = in_valid & ~clear & ~pat_load;
    assign match_now = accept && (fill_nxt == FULL) && (hist_nxt == pat_reg);

    // Without overlap the matching edge restarts the fill count.
    sd_shift_hist #(
        .PAT_W (PAT_W),
        .FILL_W(FILL_W)
    ) u_hist (
        .clk     (clk),
        .flush   (clear | pat_load),
        .shift_en(accept),
        .fill_rst((OVERLAP == 1'b0) && match_now),
        .in      (in),
        .hist_nxt(hist_nxt),
        .fill_nxt(fill_nxt)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            pat_reg <= PATTERN;
        end else if (pat_load) begin
            pat_reg <= pat_in;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= FILLING;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (pat_load) begin
            state_nxt = FILLING;
        end else if (accept) begin
            if (match_now) begin
                state_nxt = MATCH;
            end else if (fill_nxt == FULL) begin
                state_nxt = ARMED;
            end else begin
                state_nxt = FILLING;
            end
        end
    end

    always_comb begin
        out = (state == MATCH);
    end

`ifdef MATCH_COUNT_EN
    localparam logic [31:0] CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF : (32'd1 << CNT_W) - 32'd1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (match_now) begin
            cnt <= CNT_W'(sat_inc(32'(cnt), CNT_MAX));
        end
    end

    assign match_count = cnt;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detect_n.sv
// Directed bench for moore_seq_detect_n: overlapping, non-overlapping and 2-bit-counter
// instances share one stimulus stream; expected counts follow MATCH_COUNT_EN.
module tb_moore_seq_detect_n;

    logic       clk;
    logic       clear;
    logic       in;
    logic       in_valid;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       out1, out0, out2;
    logic [7:0] cnt1, cnt0;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    moore_seq_detect_n #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov1 (
        .clk(clk), .clear(clear), .in(in), .in_valid(in_valid), .pat_load(pat_load),
        .pat_in(pat_in), .out(out1), .match_count(cnt1)
    );

    moore_seq_detect_n #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_ov0 (
        .clk(clk), .clear(clear), .in(in), .in_valid(in_valid), .pat_load(pat_load),
        .pat_in(pat_in), .out(out0), .match_count(cnt0)
    );

    moore_seq_detect_n #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_c2 (
        .clk(clk), .clear(clear), .in(in), .in_valid(in_valid), .pat_load(pat_load),
        .pat_in(pat_in), .out(out2), .match_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ec(input int v);
`ifdef MATCH_COUNT_EN
        return 32'(v);
`else
        return 32'd0 + 32'(v * 0);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic b, input logic v, input logic c, input logic pl);
        @(negedge clk);
        in       = b;
        in_valid = v;
        clear    = c;
        pat_load = pl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic e1, input logic e0);
        check({tag, "_out_ov1"}, 32'(out1), 32'(e1));
        check({tag, "_out_ov0"}, 32'(out0), 32'(e0));
        check({tag, "_out_c2"},  32'(out2), 32'(e1));
    endtask

    task automatic check_cnts(input string tag, input int c1, input int c0, input int c2);
        check({tag, "_cnt_ov1"}, 32'(cnt1), ec(c1));
        check({tag, "_cnt_ov0"}, 32'(cnt0), ec(c0));
        check({tag, "_cnt_c2"},  32'(cnt2), ec(c2));
    endtask

    // Streams n bits MSB first; e1/e0 give the expected out after each bit.
    task automatic send(input string tag, input logic [31:0] bits, input int n,
                        input logic [31:0] e1, input logic [31:0] e0);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b1, 1'b0, 1'b0);
            check_outs($sformatf("%s_b%0d", tag, n - i), e1[i], e0[i]);
        end
    endtask

    initial begin
        clear    = 1'b1;
        in       = 1'b0;
        in_valid = 1'b0;
        pat_load = 1'b0;
        pat_in   = 4'b0000;

        step(1'b0, 1'b1, 1'b1, 1'b0);
        check_outs("reset", 1'b0, 1'b0);
        check_cnts("reset", 0, 0, 0);

        send("t1", 32'b1011001011, 10, 32'b0001000001, 32'b0001000001);
        check_cnts("t1", 2, 2, 2);

        step(1'b0, 1'b1, 1'b1, 1'b0);
        send("t2", 32'b1011011, 7, 32'b0001001, 32'b0001000);
        check_cnts("t2", 2, 1, 2);

        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check_outs($sformatf("t3_hold%0d", k), 1'b1, 1'b0);
            check_cnts($sformatf("t3_hold%0d", k), 2, 1, 2);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_outs("t3_drop", 1'b0, 1'b0);
        check_cnts("t3_drop", 2, 1, 2);

        send("t4a", 32'b11, 2, 32'b01, 32'b01);
        check_cnts("t4a", 3, 2, 3);
        pat_in = 4'b0110;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check_outs("t4_load", 1'b0, 1'b0);
        check_cnts("t4_load", 3, 2, 3);
        send("t4b", 32'b0110, 4, 32'b0001, 32'b0001);
        check_cnts("t4b", 4, 3, 3);

        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_outs("t5_clear", 1'b0, 1'b0);
        check_cnts("t5_clear", 0, 0, 0);
        send("t5", 32'b1011, 4, 32'b0001, 32'b0001);
        check_cnts("t5", 1, 1, 1);

        send("t6", 32'b011011011011, 12, 32'b001001001001, 32'b000001000001);
        check_cnts("t6", 5, 3, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
